// File: rtl/cond_logic.sv
// Condition-check unit: holds the NZCV register, evaluates the ARM condition field and
// registers the qualified PC/register/memory write enables. COND_STATS_EN adds exec/skip counters.
module cond_logic #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             out_valid,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags
`ifdef COND_STATS_EN
    ,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
`endif
);

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    logic [3:0] flags_q,     flags_d;
    logic       out_valid_q, out_valid_d;
    logic       pc_src_q,    pc_src_d;
    logic       reg_write_q, reg_write_d;
    logic       mem_write_q, mem_write_d;

    logic       flag_n, flag_z, flag_c, flag_v;
    logic       cond_ex;
    logic       ex;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Evaluated against the architectural register only, so a flag write lands one cycle later.
    always_comb begin
        cond_ex = 1'b0;
        unique case (cond_e'(Cond))
            COND_EQ: cond_ex = flag_z;
            COND_NE: cond_ex = ~flag_z;
            COND_CS: cond_ex = flag_c;
            COND_CC: cond_ex = ~flag_c;
            COND_MI: cond_ex = flag_n;
            COND_PL: cond_ex = ~flag_n;
            COND_VS: cond_ex = flag_v;
            COND_VC: cond_ex = ~flag_v;
            COND_HI: cond_ex = flag_c & ~flag_z;
            COND_LS: cond_ex = ~flag_c | flag_z;
            COND_GE: cond_ex = (flag_n == flag_v);
            COND_LT: cond_ex = (flag_n != flag_v);
            COND_GT: cond_ex = ~flag_z & (flag_n == flag_v);
            COND_LE: cond_ex = flag_z | (flag_n != flag_v);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

    assign ex = in_valid & cond_ex;

    always_comb begin
        flags_d     = flags_q;
        out_valid_d = in_valid;
        pc_src_d    = ex & PCS;
        reg_write_d = ex & RegW & ~NoWrite;
        mem_write_d = ex & MemW;
        if (ex && FlagW[1]) begin
            flags_d[3:2] = ALUFlags[3:2];
        end
        if (ex && FlagW[0]) begin
            flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q     <= 4'b0000;
            out_valid_q <= 1'b0;
            pc_src_q    <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            pc_src_q    <= pc_src_d;
            reg_write_q <= reg_write_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign CondEx    = cond_ex;
    assign Flags     = flags_q;
    assign out_valid = out_valid_q;
    assign PCSrc     = pc_src_q;
    assign RegWrite  = reg_write_q;
    assign MemWrite  = mem_write_q;

`ifdef COND_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        exec_cnt_d = exec_cnt_q;
        skip_cnt_d = skip_cnt_q;
        if (ex && (exec_cnt_q != CNT_MAX)) begin
            exec_cnt_d = exec_cnt_q + CNT_W'(1);
        end
        if (in_valid && !cond_ex && (skip_cnt_q != CNT_MAX)) begin
            skip_cnt_d = skip_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_cnt_q <= '0;
            skip_cnt_q <= '0;
        end else begin
            exec_cnt_q <= exec_cnt_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign exec_cnt = exec_cnt_q;
    assign skip_cnt = skip_cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule
